// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers per-digit hex values from a multiplexed active-low 7-segment scan.
// Optional decimal-point monitoring is enabled by defining SEG7_DP_EN.
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int NUM_DIGITS    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  an_n,
    input  logic [6:0]  seg_n,
`ifdef SEG7_DP_EN
    input  logic        dp_n,
    output logic [7:0]  dp_flags,
`endif
    output logic [31:0] digits,
    output logic [7:0]  digit_valid,
    output logic [7:0]  digit_err,
    output logic        upd,
    output logic [2:0]  upd_idx,
    output logic        frame_done
);

`ifdef SEG7_DP_EN
    localparam int SW = 16;
`else
    localparam int SW = 15;
`endif
    localparam logic [7:0]            STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] FULL_MASK  = '1;
    localparam logic [NUM_DIGITS-1:0] ONE_MASK   = NUM_DIGITS'(1);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_EVAL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Returns {legal, value}; segment order A..G from MSB to LSB.
    function automatic logic [4:0] glyph_decode(input logic [6:0] seg_low);
        logic [6:0] seg_on;
        seg_on = ~seg_low;
        case (seg_on)
            7'b1111110: return 5'b1_0000;
            7'b0110000: return 5'b1_0001;
            7'b1101101: return 5'b1_0010;
            7'b1111001: return 5'b1_0011;
            7'b0110011: return 5'b1_0100;
            7'b1011011: return 5'b1_0101;
            7'b1011111: return 5'b1_0110;
            7'b1110000: return 5'b1_0111;
            7'b1111111: return 5'b1_1000;
            7'b1111011: return 5'b1_1001;
            7'b1110111: return 5'b1_1010;
            7'b0011111: return 5'b1_1011;
            7'b1001110: return 5'b1_1100;
            7'b0111101: return 5'b1_1101;
            7'b1001111: return 5'b1_1110;
            7'b1000111: return 5'b1_1111;
            default:    return 5'b0_0000;
        endcase
    endfunction

    // Returns {exactly_one_low, index_of_low_anode}.
    function automatic logic [3:0] anode_select(input logic [7:0] an_low);
        logic [3:0] zeros;
        logic [2:0] idx;
        zeros = 4'd0;
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!an_low[i]) begin
                zeros = zeros + 4'd1;
                idx   = 3'(i);
            end
        end
        return {(zeros == 4'd1), idx};
    endfunction

    logic [SW-1:0]         raw_s;
    logic [SW-1:0]         sync1_r;
    logic [SW-1:0]         samp_r;
    logic [SW-1:0]         prev_r;
    logic [7:0]            cnt_r;
    logic [7:0]            cnt_next_s;
    logic                  stable_s;
    logic [3:0]            sel_s;
    logic [4:0]            glyph_s;
    logic [NUM_DIGITS-1:0] frame_mask_r;
    logic [NUM_DIGITS-1:0] mask_set_s;
    state_t                state_r;

`ifdef SEG7_DP_EN
    assign raw_s = {dp_n, an_n, seg_n};
`else
    assign raw_s = {an_n, seg_n};
`endif

    // Decode from prev_r so a change landing on the EVAL cycle still evaluates the stable slot.
    always_comb begin
        stable_s = (samp_r == prev_r);
        if (!stable_s) begin
            cnt_next_s = 8'd0;
        end else if (cnt_r < STABLE_MAX) begin
            cnt_next_s = cnt_r + 8'd1;
        end else begin
            cnt_next_s = cnt_r;
        end
        sel_s      = anode_select(prev_r[14:7]);
        glyph_s    = glyph_decode(prev_r[6:0]);
        mask_set_s = frame_mask_r | (ONE_MASK << sel_s[2:0]);
    end

    // Synchronizer, stability counter, scan FSM and registered capture outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r      <= '1;
            samp_r       <= '1;
            prev_r       <= '1;
            cnt_r        <= 8'd0;
            state_r      <= ST_WAIT;
            frame_mask_r <= '0;
            digits       <= 32'd0;
            digit_valid  <= 8'd0;
            digit_err    <= 8'd0;
            upd          <= 1'b0;
            upd_idx      <= 3'd0;
            frame_done   <= 1'b0;
`ifdef SEG7_DP_EN
            dp_flags     <= 8'd0;
`endif
        end else begin
            sync1_r    <= raw_s;
            samp_r     <= sync1_r;
            prev_r     <= samp_r;
            cnt_r      <= cnt_next_s;
            upd        <= 1'b0;
            frame_done <= 1'b0;
            case (state_r)
                ST_WAIT: begin
                    if (cnt_next_s == STABLE_MAX) begin
                        state_r <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    state_r <= stable_s ? ST_HOLD : ST_WAIT;
                    if (sel_s[3]) begin
                        upd     <= 1'b1;
                        upd_idx <= sel_s[2:0];
                        if (glyph_s[4]) begin
                            digits[{sel_s[2:0], 2'b00} +: 4] <= glyph_s[3:0];
                            digit_valid[sel_s[2:0]]          <= 1'b1;
                            digit_err[sel_s[2:0]]            <= 1'b0;
                        end else begin
                            digit_err[sel_s[2:0]] <= 1'b1;
                        end
`ifdef SEG7_DP_EN
                        dp_flags[sel_s[2:0]] <= ~prev_r[15];
`endif
                        if (mask_set_s == FULL_MASK) begin
                            frame_done   <= 1'b1;
                            frame_mask_r <= '0;
                        end else begin
                            frame_mask_r <= mask_set_s;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stable_s) begin
                        state_r <= ST_WAIT;
                    end
                end
                default: state_r <= ST_WAIT;
            endcase
        end
    end

endmodule
